data_mem: RTL and testbench

- Data-memory stage target for the 5-stage RV32I core.
- Consumes the core's MA-stage outputs (wem, rwmm, rwam, wdm) and returns rdm in the same cycle; the core samples rdm into its MA->WB register.
- Provides a word-organised RAM with byte/halfword lanes and RV32I load extension.
- Provides a small MMIO window: tohost/halt, a free-running 64-bit cycle counter and a console byte port for simulation and bring-up.

---
 rtl/data_mem_pkg.sv | 36 +++
 rtl/data_mem_if.sv | 15 +
 rtl/data_mem_load_extract.sv | 48 ++++
 rtl/data_mem.sv | 178 +++++++++++++++++
 tb/tb_data_mem.sv | 276 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/data_mem_pkg.sv
// mem_pkg: shared definitions for the data_mem stage.
//   - RV32I funct3 load/store size encodings (MEM_*)
//   - MMIO word offsets within the 16-byte window (MMIO_*)
//   - helpers classifying an access mode
package mem_pkg;

  localparam logic [2:0] MEM_B  = 3'b000;
  localparam logic [2:0] MEM_H  = 3'b001;
  localparam logic [2:0] MEM_W  = 3'b010;
  localparam logic [2:0] MEM_BU = 3'b100;
  localparam logic [2:0] MEM_HU = 3'b101;

  localparam logic [1:0] MMIO_TOHOST   = 2'd0;
  localparam logic [1:0] MMIO_CYCLE_LO = 2'd1;
  localparam logic [1:0] MMIO_CYCLE_HI = 2'd2;
  localparam logic [1:0] MMIO_CONSOLE  = 2'd3;

  // Only the three store encodings write; the unsigned-load encodings have no
  // store meaning, and the reserved encodings are ignored.
  function automatic logic store_mode(input logic [2:0] mode);
    case (mode)
      MEM_B, MEM_H, MEM_W: return 1'b1;
      default:             return 1'b0;
    endcase
  endfunction

  // Half accesses must be 2-byte aligned, word accesses 4-byte aligned.
  function automatic logic is_misaligned(input logic [2:0] mode, input logic [1:0] lsb);
    case (mode)
      MEM_H, MEM_HU: return lsb[0];
      MEM_W:         return (lsb != 2'b00);
      default:       return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/data_mem_if.sv
// data_mem_if: the core's memory-access bus toward data_mem.
//   wem  - store enable          rwmm - funct3 access mode
//   rwam - byte address          wdm  - store data (right-aligned)
//   rdm  - load data, extended, returned in the same cycle
// master = core side, slave = memory side.
interface data_mem_if;
  logic        wem;
  logic [2:0]  rwmm;
  logic [31:0] rwam;
  logic [31:0] wdm;
  logic [31:0] rdm;

  modport master (output wem, output rwmm, output rwam, output wdm, input rdm);
  modport slave  (input wem, input rwmm, input rwam, input wdm, output rdm);
endinterface

// File: rtl/data_mem_load_extract.sv
// load_extract: combinational lane select plus sign/zero extension.
//   word_i - 32-bit source word      addr_i - byte offset within the word
//   mode_i - funct3 access mode      data_o - extended load result
// Half accesses use addr_i[1] only, so a misaligned half reads the aligned half.
// Reserved modes return 0.
module load_extract
  import mem_pkg::*;
(
  input  logic [31:0] word_i,
  input  logic [1:0]  addr_i,
  input  logic [2:0]  mode_i,
  output logic [31:0] data_o
);

  logic [7:0]  byte_s;
  logic [15:0] half_s;

  // Pick the addressed byte and half out of the word.
  always_comb begin
    byte_s = 8'h00;
    case (addr_i)
      2'd0:    byte_s = word_i[7:0];
      2'd1:    byte_s = word_i[15:8];
      2'd2:    byte_s = word_i[23:16];
      2'd3:    byte_s = word_i[31:24];
      default: byte_s = 8'h00;
    endcase
    if (addr_i[1]) begin
      half_s = word_i[31:16];
    end else begin
      half_s = word_i[15:0];
    end
  end

  // Extend the selected lane according to the access mode.
  always_comb begin
    data_o = 32'h0000_0000;
    case (mode_i)
      MEM_B:   data_o = {{24{byte_s[7]}}, byte_s};
      MEM_BU:  data_o = {24'h00_0000, byte_s};
      MEM_H:   data_o = {{16{half_s[15]}}, half_s};
      MEM_HU:  data_o = {16'h0000, half_s};
      MEM_W:   data_o = word_i;
      default: data_o = 32'h0000_0000;
    endcase
  end

endmodule

// File: rtl/data_mem.sv
// data_mem: data-memory stage target for the 5-stage RV32I core.
//   clk, reset    - rising-edge clock, asynchronous active-high reset
//   bus (slave)   - wem/rwmm/rwam/wdm in, rdm out (combinational, zero latency)
//   halt          - sticky, set by a nonzero tohost write
//   tohost        - last value written to tohost
//   console_valid - one-cycle pulse after a console write
//   console_data  - byte captured by the last console write
//   misaligned    - sticky, a misaligned half/word access was seen
// Word RAM with byte lanes plus a 16-byte MMIO window at MMIO_BASE holding
// tohost, a 64-bit free-running cycle counter and a console byte port.
module data_mem
  import mem_pkg::*;
#(
  parameter int          DEPTH_WORDS = 1024,
  parameter string       MEMFILE     = "",
  parameter logic [31:0] MMIO_BASE   = 32'hFFFF_FF00
) (
  input  logic        clk,
  input  logic        reset,
  data_mem_if.slave   bus,
  output logic        halt,
  output logic [31:0] tohost,
  output logic        console_valid,
  output logic [7:0]  console_data,
  output logic        misaligned
);

  localparam int AW = $clog2(DEPTH_WORDS);

  logic [31:0] mem_q [DEPTH_WORDS];

  logic [AW-1:0] idx_s;
  logic          mmio_hit_s;
  logic [1:0]    mmio_off_s;
  logic          store_s;
  logic          ram_we_s;
  logic [3:0]    be_s;
  logic [31:0]   wdata_s;
  logic [31:0]   mmio_rdata_s;
  logic [31:0]   word_s;
  logic [31:0]   rdm_s;

  logic        halt_q, halt_d;
  logic [31:0] tohost_q, tohost_d;
  logic        cvalid_q, cvalid_d;
  logic [7:0]  cdata_q, cdata_d;
  logic        mis_q, mis_d;
  logic [63:0] cycle_q, cycle_d;

  // Upper address bits above the RAM index are ignored, so RAM aliases.
  assign idx_s      = bus.rwam[AW+1:2];
  assign mmio_hit_s = (bus.rwam[31:4] == MMIO_BASE[31:4]);
  assign mmio_off_s = bus.rwam[3:2];
  assign store_s    = bus.wem && store_mode(bus.rwmm);
  assign ram_we_s   = store_s && !mmio_hit_s;

  // Byte enables and lane-replicated store data; ignored low address bits act as 0.
  always_comb begin
    be_s    = 4'b0000;
    wdata_s = 32'h0000_0000;
    case (bus.rwmm)
      MEM_B: begin
        be_s    = 4'b0001 << bus.rwam[1:0];
        wdata_s = {4{bus.wdm[7:0]}};
      end
      MEM_H: begin
        be_s    = bus.rwam[1] ? 4'b1100 : 4'b0011;
        wdata_s = {2{bus.wdm[15:0]}};
      end
      MEM_W: begin
        be_s    = 4'b1111;
        wdata_s = bus.wdm;
      end
      default: begin
        be_s    = 4'b0000;
        wdata_s = 32'h0000_0000;
      end
    endcase
  end

  // MMIO read word; console is write-only and reads as 0.
  always_comb begin
    mmio_rdata_s = 32'h0000_0000;
    case (mmio_off_s)
      MMIO_TOHOST:   mmio_rdata_s = tohost_q;
      MMIO_CYCLE_LO: mmio_rdata_s = cycle_q[31:0];
      MMIO_CYCLE_HI: mmio_rdata_s = cycle_q[63:32];
      default:       mmio_rdata_s = 32'h0000_0000;
    endcase
  end

  // Read source select: reads see pre-edge RAM contents (old data on same-cycle write).
  always_comb begin
    if (mmio_hit_s) begin
      word_s = mmio_rdata_s;
    end else begin
      word_s = mem_q[idx_s];
    end
  end

  load_extract u_extract (
    .word_i (word_s),
    .addr_i (bus.rwam[1:0]),
    .mode_i (bus.rwmm),
    .data_o (rdm_s)
  );

  assign bus.rdm = rdm_s;

  // RAM byte-lane write; a store coinciding with reset is dropped.
  always_ff @(posedge clk) begin
    if (ram_we_s && !reset) begin
      for (int b = 0; b < 4; b++) begin
        if (be_s[b]) begin
          mem_q[idx_s][8*b +: 8] <= wdata_s[8*b +: 8];
        end
      end
    end
  end

  // Next state of the MMIO and status registers.
  always_comb begin
    halt_d   = halt_q;
    tohost_d = tohost_q;
    cvalid_d = 1'b0;
    cdata_d  = cdata_q;
    mis_d    = mis_q | is_misaligned(bus.rwmm, bus.rwam[1:0]);
    cycle_d  = cycle_q + 64'd1;
    if (store_s && mmio_hit_s) begin
      case (mmio_off_s)
        MMIO_TOHOST: begin
          tohost_d = bus.wdm;
          if (bus.wdm != 32'h0000_0000) begin
            halt_d = 1'b1;
          end else begin
            halt_d = halt_q;
          end
        end
        MMIO_CONSOLE: begin
          cvalid_d = 1'b1;
          cdata_d  = bus.wdm[7:0];
        end
        default: begin
          // cycle_lo/cycle_hi are read-only: writes are ignored.
          halt_d = halt_q;
        end
      endcase
    end else begin
      tohost_d = tohost_q;
    end
  end

  // State registers with asynchronous reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      halt_q   <= 1'b0;
      tohost_q <= 32'h0000_0000;
      cvalid_q <= 1'b0;
      cdata_q  <= 8'h00;
      mis_q    <= 1'b0;
      cycle_q  <= 64'h0;
    end else begin
      halt_q   <= halt_d;
      tohost_q <= tohost_d;
      cvalid_q <= cvalid_d;
      cdata_q  <= cdata_d;
      mis_q    <= mis_d;
      cycle_q  <= cycle_d;
    end
  end

  assign halt          = halt_q;
  assign tohost        = tohost_q;
  assign console_valid = cvalid_q;
  assign console_data  = cdata_q;
  assign misaligned    = mis_q;

endmodule

// File: tb/tb_data_mem.sv
// Self-checking bench for data_mem: directed table, hand sequences for the
// multi-cycle corner cases, and randomized RAM traffic against a byte-array model.
module tb_data_mem;
  import mem_pkg::*;

  localparam logic [31:0] BASE = 32'hFFFF_FF00;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        halt;
  logic [31:0] tohost;
  logic        console_valid;
  logic [7:0]  console_data;
  logic        misaligned;

  int tests = 0;
  int failed = 0;

  data_mem_if bus ();

  data_mem #(.DEPTH_WORDS(1024), .MEMFILE(""), .MMIO_BASE(BASE)) dut (
    .clk           (clk),
    .reset         (reset),
    .bus           (bus),
    .halt          (halt),
    .tohost        (tohost),
    .console_valid (console_valid),
    .console_data  (console_data),
    .misaligned    (misaligned)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  typedef struct {
    logic        we;
    logic [2:0]  mode;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[$];

  // Reference RAM: 4 KiB of bytes, byte address taken modulo the RAM size.
  logic [7:0] model [4096];
  logic       exp_mis;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      failed++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // Present one access just after the falling edge; rdm is valid #1 later.
  task automatic cyc(input logic we, input logic [2:0] mode, input logic [31:0] addr,
                     input logic [31:0] data);
    @(negedge clk);
    bus.wem  = we;
    bus.rwmm = mode;
    bus.rwam = addr;
    bus.wdm  = data;
    #1;
  endtask

  // Let the rising edge happen, then sample registered outputs.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic vec_t mk(input logic we, input logic [2:0] mode, input logic [31:0] addr,
                              input logic [31:0] wdata, input logic [31:0] exp);
    vec_t v;
    v.we = we; v.mode = mode; v.addr = addr; v.wdata = wdata; v.exp = exp;
    return v;
  endfunction

  function automatic logic [31:0] model_read(input logic [2:0] mode, input logic [31:0] addr);
    int a;
    logic [7:0]  b;
    logic [15:0] h;
    a = int'(addr % 32'd4096);
    case (mode)
      3'b000: begin b = model[a]; return {{24{b[7]}}, b}; end
      3'b100: begin b = model[a]; return {24'h0, b}; end
      3'b001: begin a = a - (a % 2); h = {model[a+1], model[a]}; return {{16{h[15]}}, h}; end
      3'b101: begin a = a - (a % 2); h = {model[a+1], model[a]}; return {16'h0, h}; end
      3'b010: begin a = a - (a % 4); return {model[a+3], model[a+2], model[a+1], model[a]}; end
      default: return 32'h0;
    endcase
  endfunction

  task automatic model_write(input logic [2:0] mode, input logic [31:0] addr, input logic [31:0] d);
    int a;
    a = int'(addr % 32'd4096);
    case (mode)
      3'b000: model[a] = d[7:0];
      3'b001: begin a = a - (a % 2); model[a] = d[7:0]; model[a+1] = d[15:8]; end
      3'b010: begin
        a = a - (a % 4);
        model[a] = d[7:0]; model[a+1] = d[15:8]; model[a+2] = d[23:16]; model[a+3] = d[31:24];
      end
      default: begin end
    endcase
  endtask

  task automatic zero_ram();
    for (int i = 0; i < 1024; i++) begin
      cyc(1'b1, MEM_W, i * 4, 32'h0);
    end
    cyc(1'b0, MEM_W, 32'h0, 32'h0);
    for (int i = 0; i < 4096; i++) model[i] = 8'h00;
  endtask

  initial begin
    bus.wem = 1'b0; bus.rwmm = MEM_W; bus.rwam = BASE + 32'h4; bus.wdm = 32'h0;

    // ---- reset state ----
    #23;
    check("rst_halt", {63'h0, halt}, 64'd0);
    check("rst_tohost", {32'h0, tohost}, 64'd0);
    check("rst_cvalid", {63'h0, console_valid}, 64'd0);
    check("rst_cdata", {56'h0, console_data}, 64'd0);
    check("rst_mis", {63'h0, misaligned}, 64'd0);
    check("rst_cycle_lo", {32'h0, bus.rdm}, 64'd0);

    // ---- cycle counter: 10 edges after release ----
    @(negedge clk);
    reset = 1'b0;
    repeat (10) @(posedge clk);
    cyc(1'b0, MEM_W, BASE + 32'h4, 32'h0);
    check("cycle_lo_10", {32'h0, bus.rdm}, 64'd10);
    bus.rwam = BASE + 32'h8;
    #1 check("cycle_hi_10", {32'h0, bus.rdm}, 64'd0);

    // ---- cycle counter wrap ----
    @(negedge clk);
    force dut.cycle_q = 64'hFFFF_FFFF_FFFF_FFFF;
    #1 release dut.cycle_q;
    bus.rwam = BASE + 32'h4;
    #1 check("cycle_lo_max", {32'h0, bus.rdm}, 64'hFFFF_FFFF);
    bus.rwam = BASE + 32'h8;
    #1 check("cycle_hi_max", {32'h0, bus.rdm}, 64'hFFFF_FFFF);
    tick();
    check("cycle_hi_wrap", {32'h0, bus.rdm}, 64'd0);
    bus.rwam = BASE + 32'h4;
    #1 check("cycle_lo_wrap", {32'h0, bus.rdm}, 64'd0);

    // ---- directed table ----
    zero_ram();
    vecs.push_back(mk(1'b1, MEM_W,  32'h100,  32'h8070_F0A1, 32'h0000_0000));
    vecs.push_back(mk(1'b0, MEM_B,  32'h100,  32'h0,         32'hFFFF_FFA1));
    vecs.push_back(mk(1'b0, MEM_BU, 32'h100,  32'h0,         32'h0000_00A1));
    vecs.push_back(mk(1'b0, MEM_BU, 32'h101,  32'h0,         32'h0000_00F0));
    vecs.push_back(mk(1'b0, MEM_B,  32'h101,  32'h0,         32'hFFFF_FFF0));
    vecs.push_back(mk(1'b0, MEM_B,  32'h103,  32'h0,         32'hFFFF_FF80));
    vecs.push_back(mk(1'b0, MEM_H,  32'h100,  32'h0,         32'hFFFF_F0A1));
    vecs.push_back(mk(1'b0, MEM_H,  32'h102,  32'h0,         32'hFFFF_8070));
    vecs.push_back(mk(1'b0, MEM_HU, 32'h102,  32'h0,         32'h0000_8070));
    vecs.push_back(mk(1'b0, MEM_W,  32'h100,  32'h0,         32'h8070_F0A1));
    vecs.push_back(mk(1'b0, 3'b011, 32'h100,  32'h0,         32'h0000_0000));
    vecs.push_back(mk(1'b1, MEM_W,  32'h200,  32'h1122_3344, 32'h0000_0000));
    vecs.push_back(mk(1'b1, MEM_B,  32'h201,  32'h0000_00AA, 32'h0000_0033)); // old byte
    vecs.push_back(mk(1'b1, MEM_H,  32'h202,  32'h0000_BBCC, 32'h0000_1122)); // old half
    vecs.push_back(mk(1'b0, MEM_W,  32'h200,  32'h0,         32'hBBCC_AA44));
    vecs.push_back(mk(1'b1, 3'b111, 32'h200,  32'hFFFF_FFFF, 32'h0000_0000));
    vecs.push_back(mk(1'b0, MEM_W,  32'h200,  32'h0,         32'hBBCC_AA44));
    vecs.push_back(mk(1'b0, MEM_W,  32'h1200, 32'h0,         32'hBBCC_AA44)); // alias
    vecs.push_back(mk(1'b1, MEM_W,  32'h4100, 32'hDEAD_BEEF, 32'h8070_F0A1)); // alias store
    vecs.push_back(mk(1'b0, MEM_W,  32'h100,  32'h0,         32'hDEAD_BEEF));
    vecs.push_back(mk(1'b0, MEM_W,  BASE + 32'hC, 32'h0,     32'h0000_0000)); // console reads 0
    vecs.push_back(mk(1'b0, MEM_W,  BASE,     32'h0,         32'h0000_0000)); // tohost
    foreach (vecs[i]) begin
      cyc(vecs[i].we, vecs[i].mode, vecs[i].addr, vecs[i].wdata);
      check($sformatf("vec%0d_rdm", i), {32'h0, bus.rdm}, {32'h0, vecs[i].exp});
    end
    tick();
    check("table_no_mis", {63'h0, misaligned}, 64'd0);

    // ---- misalignment ----
    cyc(1'b0, MEM_W, 32'h101, 32'h0);
    check("mis_lw_rdm", {32'h0, bus.rdm}, 64'hDEAD_BEEF);
    check("mis_before_edge", {63'h0, misaligned}, 64'd0);
    tick();
    check("mis_set", {63'h0, misaligned}, 64'd1);
    cyc(1'b0, MEM_H, 32'h103, 32'h0);
    check("mis_lh_rdm", {32'h0, bus.rdm}, 64'hFFFF_DEAD);
    cyc(1'b0, MEM_W, 32'h100, 32'h0);
    tick();
    check("mis_sticky", {63'h0, misaligned}, 64'd1);

    // ---- mid-cycle reset clears at once; store during reset dropped ----
    @(negedge clk);
    #2 reset = 1'b1;
    #1 check("mis_async_clr", {63'h0, misaligned}, 64'd0);
    bus.wem = 1'b1; bus.rwmm = MEM_W; bus.rwam = 32'h300; bus.wdm = 32'h1234_5678;
    tick();
    @(negedge clk);
    reset = 1'b0;
    bus.wem = 1'b0;
    cyc(1'b0, MEM_W, 32'h300, 32'h0);
    check("store_in_reset_dropped", {32'h0, bus.rdm}, 64'd0);
    cyc(1'b0, MEM_W, 32'h100, 32'h0);
    check("ram_kept_over_reset", {32'h0, bus.rdm}, 64'hDEAD_BEEF);

    // ---- tohost / halt ----
    cyc(1'b1, MEM_W, BASE, 32'h0);
    tick();
    check("halt_zero_write", {63'h0, halt}, 64'd0);
    cyc(1'b1, MEM_W, BASE, 32'h1);
    check("halt_before_edge", {63'h0, halt}, 64'd0);
    tick();
    check("halt_set", {63'h0, halt}, 64'd1);
    check("tohost_1", {32'h0, tohost}, 64'd1);
    cyc(1'b0, MEM_W, BASE, 32'h0);
    check("tohost_read", {32'h0, bus.rdm}, 64'd1);
    cyc(1'b1, MEM_W, BASE, 32'h0);
    tick();
    check("halt_sticky", {63'h0, halt}, 64'd1);
    check("tohost_0", {32'h0, tohost}, 64'd0);

    // ---- console back-to-back ----
    cyc(1'b1, MEM_B, BASE + 32'hC, 32'h48);
    tick();
    check("con_valid_1", {63'h0, console_valid}, 64'd1);
    check("con_data_1", {56'h0, console_data}, 64'h48);
    cyc(1'b1, MEM_B, BASE + 32'hC, 32'h69);
    tick();
    check("con_valid_2", {63'h0, console_valid}, 64'd1);
    check("con_data_2", {56'h0, console_data}, 64'h69);
    cyc(1'b0, MEM_W, 32'h0, 32'h0);
    tick();
    check("con_valid_end", {63'h0, console_valid}, 64'd0);
    check("con_data_hold", {56'h0, console_data}, 64'h69);

    // ---- randomized RAM traffic against the byte model ----
    @(negedge clk);
    reset = 1'b1;
    #2 reset = 1'b0;
    zero_ram();
    exp_mis = 1'b0;
    for (int i = 0; i < 500; i++) begin
      logic        we;
      logic [2:0]  mode;
      logic [31:0] addr;
      logic [31:0] data;
      we   = 1'($urandom_range(0, 1));
      mode = 3'($urandom_range(0, 7));
      addr = 32'($urandom_range(0, 16383));
      data = $urandom;
      cyc(we, mode, addr, data);
      check($sformatf("rnd%0d_rdm", i), {32'h0, bus.rdm}, {32'h0, model_read(mode, addr)});
      if (we && (mode == 3'b000 || mode == 3'b001 || mode == 3'b010)) begin
        model_write(mode, addr, data);
      end
      if (((mode == 3'b001 || mode == 3'b101) && (addr % 2 != 0)) ||
          (mode == 3'b010 && (addr % 4 != 0))) begin
        exp_mis = 1'b1;
      end
      tick();
      check($sformatf("rnd%0d_mis", i), {63'h0, misaligned}, {63'h0, exp_mis});
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
